spi_shift_reg: RTL

- Parametrised SPI data register: parallel-load / serial-shift / parallel-capture, with a bit counter and completion flag.
- Generalises the fixed 10-bit enabled holding register to any width and either bit order.
- Adds frame tracking: busy while shifting, done pulse on completion, captured receive word.
- Sits between the SPI clock/sequencing logic (which issues shift strobes) and the parallel data path.

---
 rtl/spi_shift_reg.sv | 90 +++++++++
 1 files changed

// File: rtl/spi_shift_reg.sv
// SPI data register: parallel load, serial shift in/out, parallel capture.
// Tracks the frame with a bit counter, busy level and done pulse.
module spi_shift_reg #(
  parameter int WIDTH     = 10,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift,
  input  logic             sdi,
  output logic             sdo,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] dout_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;

  always_comb begin
    if (LSB_FIRST) shifted = {sdi, sreg[WIDTH-1:1]};
    else           shifted = {sreg[WIDTH-2:0], sdi};
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    dout_nxt  = data_out;
    cnt_nxt   = bit_cnt;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        // load wins over a coincident shift
        if (ena && load) begin
          sreg_nxt  = data_in;
          cnt_nxt   = CNT_W'(WIDTH);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ena && shift) begin
          sreg_nxt = shifted;
          cnt_nxt  = bit_cnt - CNT_W'(1);
          if (bit_cnt == CNT_W'(1)) begin
            dout_nxt  = shifted;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      data_out <= '0;
      bit_cnt  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      data_out <= dout_nxt;
      bit_cnt  <= cnt_nxt;
      done     <= done_nxt;
    end
  end

  assign busy = (state == SHIFT);
  assign sdo  = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];

endmodule
